// File: rtl/gshare_pkg.sv
// gshare_pkg: shared defaults and the in-flight branch queue entry layout.
package gshare_pkg;
    localparam int GHR_W_DEF = 8;
    localparam int DEPTH_DEF = 4;
    typedef struct packed {
        logic [GHR_W_DEF-1:0] index;
        logic                 pred;
        logic [GHR_W_DEF-1:0] ghr;
    } gshare_entry_t;
endpackage

// File: rtl/gshare_inflight_fifo.sv
// gshare_inflight_fifo: in-order queue of unresolved branches; flush wins over push.
module gshare_inflight_fifo
    import gshare_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = gshare_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    entry_t      mem [DEPTH];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/gshare_predict_ctrl.sv
// gshare_predict_ctrl: gshare lookup indexing, speculative history and resolve/recovery control.
// Optional GSHARE_STATS_EN adds saturating lookup/mispredict counters.
module gshare_predict_ctrl
    import gshare_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int GHR_W = GHR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             lookup_ready,
    output logic [GHR_W-1:0] bpb_index,
    input  logic             bpb_predict_taken,
    output logic             predict_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             mispredict,
    output logic             bpb_update,
    output logic [GHR_W-1:0] bpb_update_index,
    output logic             bpb_update_taken,
    output logic             resolve_err
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_mispredicts
`endif
);
    typedef struct packed {
        logic [GHR_W-1:0] index;
        logic             pred;
        logic [GHR_W-1:0] ghr;
    } entry_t;
    logic [GHR_W-1:0] spec_ghr;
    entry_t           head, din;
    logic             full, empty, pop, accept;
    logic             unused_bits;
    assign bpb_index     = lookup_pc[GHR_W+1:2] ^ spec_ghr;
    assign predict_taken = bpb_predict_taken;
    assign pop           = !rst && resolve_valid && !empty;
    assign mispredict    = pop && (resolve_taken ^ head.pred);
    // No bypass: a slot freed by this cycle's resolve is not reusable until next cycle.
    assign lookup_ready  = !rst && !full && !mispredict;
    assign accept        = lookup_valid && lookup_ready;
    assign din           = '{bpb_index, bpb_predict_taken, spec_ghr};
    assign unused_bits   = ^{lookup_pc[PC_W-1:GHR_W+2], lookup_pc[1:0], head.ghr[GHR_W-1]};
    gshare_inflight_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .flush (mispredict),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr         <= '0;
            bpb_update       <= 1'b0;
            bpb_update_index <= '0;
            bpb_update_taken <= 1'b0;
            resolve_err      <= 1'b0;
        end else begin
            // Recovery rebuilds history from the snapshot taken when the bad branch was fetched.
            spec_ghr    <= mispredict ? {head.ghr[GHR_W-2:0], resolve_taken}
                         : accept     ? {spec_ghr[GHR_W-2:0], bpb_predict_taken}
                         : spec_ghr;
            bpb_update  <= pop;
            resolve_err <= resolve_err || (resolve_valid && empty);
            if (pop) begin
                bpb_update_index <= head.index;
                bpb_update_taken <= resolve_taken;
            end
        end
    end
`ifdef GSHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept && !(&stat_lookups)) stat_lookups <= stat_lookups + 1'b1;
            if (mispredict && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_gshare_predict_ctrl.sv
// tb_gshare_predict_ctrl: directed and random checks against a queue-based reference model.
module tb_gshare_predict_ctrl;
    localparam int DEPTH = 4;
    logic        clk = 0;
    logic        rst = 1;
    logic        lookup_valid = 0;
    logic [31:0] lookup_pc = 0;
    logic        lookup_ready;
    logic [7:0]  bpb_index;
    logic        bpb_predict_taken = 0;
    logic        predict_taken;
    logic        resolve_valid = 0;
    logic        resolve_taken = 0;
    logic        mispredict;
    logic        bpb_update;
    logic [7:0]  bpb_update_index;
    logic        bpb_update_taken;
    logic        resolve_err;
    gshare_predict_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .lookup_ready      (lookup_ready),
        .bpb_index         (bpb_index),
        .bpb_predict_taken (bpb_predict_taken),
        .predict_taken     (predict_taken),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .mispredict        (mispredict),
        .bpb_update        (bpb_update),
        .bpb_update_index  (bpb_update_index),
        .bpb_update_taken  (bpb_update_taken),
        .resolve_err       (resolve_err)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] idx;
        logic       pred;
        logic [7:0] ghr;
    } ment_t;
    ment_t      m_q[$];
    logic [7:0] m_ghr = 0;
    logic       m_upd = 0;
    logic [7:0] m_uidx = 0;
    logic       m_utak = 0;
    logic       m_err = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] s_idx;
    logic       s_pred, s_ready, s_mis, s_upd, s_utak, s_err;
    logic [7:0] s_uidx;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc(input logic r, input logic lv, input logic [31:0] pc,
                       input logic pt, input logic rv, input logic rt);
        logic [7:0] e_idx;
        logic       e_mis, e_ready, e_acc;
        @(negedge clk);
        rst = r; lookup_valid = lv; lookup_pc = pc; bpb_predict_taken = pt;
        resolve_valid = rv; resolve_taken = rt;
        #1;
        e_idx   = pc[9:2] ^ m_ghr;
        e_mis   = !r && rv && m_q.size() > 0 && rt != m_q[0].pred;
        e_ready = !r && m_q.size() < DEPTH && !e_mis;
        e_acc   = lv && e_ready;
        s_idx = bpb_index; s_pred = predict_taken; s_ready = lookup_ready; s_mis = mispredict;
        s_upd = bpb_update; s_uidx = bpb_update_index; s_utak = bpb_update_taken; s_err = resolve_err;
        chk("bpb_index", s_idx, e_idx);
        chk("predict_taken", s_pred, pt);
        chk("lookup_ready", s_ready, e_ready);
        chk("mispredict", s_mis, e_mis);
        chk("bpb_update", s_upd, m_upd);
        chk("bpb_update_index", s_uidx, m_uidx);
        chk("bpb_update_taken", s_utak, m_utak);
        chk("resolve_err", s_err, m_err);
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_ghr = 0; m_upd = 0; m_uidx = 0; m_utak = 0; m_err = 0;
        end else begin
            m_upd = rv && m_q.size() > 0;
            if (m_upd) begin
                m_uidx = m_q[0].idx;
                m_utak = rt;
            end
            if (rv && m_q.size() == 0) m_err = 1;
            if (e_mis) begin
                m_ghr = {m_q[0].ghr[6:0], rt};
                m_q.delete();
            end else begin
                if (m_upd) void'(m_q.pop_front());
                if (e_acc) begin
                    m_q.push_back('{e_idx, pt, m_ghr});
                    m_ghr = {m_ghr[6:0], pt};
                end
            end
        end
    endtask
    initial begin
        logic [7:0] bits;
        logic       rv;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h40, 1, 1, 1);
        chk("reset_ready", s_ready, 0);
        chk("reset_mispredict", s_mis, 0);
        cyc(0, 1, 32'h10, 1, 0, 0);
        chk("first_index", s_idx, 8'h04);
        chk("first_predict", s_pred, 1);
        chk("post_reset_update", s_upd, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("ghr_after_first", s_idx, 8'h01);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("full_ready", s_ready, 0);
        cyc(0, 1, 0, 1, 1, 1);
        chk("full_resolve_no_bypass", s_ready, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("ready_after_resolve", s_ready, 1);
        chk("update_after_resolve", s_upd, 1);
        chk("update_index_first", s_uidx, 8'h04);
        chk("swap_index", s_idx, 8'h08);
        cyc(0, 0, 0, 0, 0, 0);
        chk("swap_update", s_upd, 1);
        chk("swap_update_index", s_uidx, 8'h01);
        chk("swap_ready", s_ready, 1);
        cyc(1, 1, 0, 1, 1, 1);
        chk("rst_mid_ready", s_ready, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_mid_update", s_upd, 0);
        chk("rst_mid_index", s_idx, 8'h00);
        chk("rst_mid_uidx", s_uidx, 8'h00);
        cyc(0, 0, 0, 0, 1, 1);
        chk("empty_resolve_mis", s_mis, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("err_set", s_err, 1);
        chk("err_no_update", s_upd, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("err_sticky", s_err, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("err_cleared", s_err, 0);
        bits = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            rv = m_q.size() > 0;
            cyc(0, 1, 0, bits[i], rv, rv ? m_q[0].pred : 1'b0);
        end
        cyc(0, 1, 0, 1, 1, m_q[0].pred);
        chk("ghr_a5", s_idx, 8'hA5);
        cyc(0, 0, 0, 0, 1, 0);
        chk("a5_mispredict", s_mis, 1);
        chk("a5_ready_low", s_ready, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("recovered_ghr", s_idx, 8'h4A);
        chk("a5_update", s_upd, 1);
        chk("a5_update_taken", s_utak, 0);
        chk("a5_update_index", s_uidx, 8'hA5);
        chk("a5_ready", s_ready, 1);
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(199) == 0, $urandom_range(9) < 7, $urandom, $urandom_range(1),
                $urandom_range(9) < 4, $urandom_range(1));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
